// File: rtl/serial_alu_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer.
// Provides the ALU op codes and the sequencer state encoding.
package serial_alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Arithmetic ops (add/sub) have op[1] clear.
    function automatic logic is_arith(input alu_op_e op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/serial_alu_seq_slice.sv
// Combinational 1-bit ALU slice: add, and, or.
// Ports: a, b, cin, op -> r, cout. Subtract is an add with b inverted upstream.
module serial_bit_slice
    import serial_alu_seq_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    r,
    output logic    cout
);

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                r    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial word sequencer: streams two WIDTH-bit operands LSB-first through
// a 1-bit ALU slice and reassembles the result word with Z/N/C/V flags.
// Ports: clk, rst (async, active-high), start, op, a, b -> busy, done,
//        result, z, n, c, v.
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    // Only WIDTH-1 bits are stored; the incoming bit completes the word.
    logic [WIDTH-2:0] res_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q, n_q, c_q, v_q;

    logic             b_bit;
    logic             slice_r;
    logic             slice_cout;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        b_bit  = b_sr_q[0] ^ (op_q == OP_SUB);
        word_d = {slice_r, res_sr_q};
    end

    serial_bit_slice u_slice (
        .a    (a_sr_q[0]),
        .b    (b_bit),
        .cin  (carry_q),
        .op   (op_q),
        .r    (slice_r),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        op_q    <= alu_op_e'(op);
                        // Sub runs as a + ~b + 1.
                        carry_q <= op[0];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry_q  <= slice_cout;
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= word_d[WIDTH-1:1];
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // carry_q is the carry into the MSB here.
                        result_q <= word_d;
                        z_q      <= (word_d == '0);
                        n_q      <= word_d[WIDTH-1];
                        c_q      <= is_arith(op_q) & slice_cout;
                        v_q      <= is_arith(op_q) & (carry_q ^ slice_cout);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign z      = z_q;
    assign n      = n_q;
    assign c      = c_q;
    assign v      = v_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq (WIDTH=8).
// Directed cases plus random vectors against an arithmetic reference model.
module tb_serial_alu_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       z, n, c, v;

    int n_vec;
    int n_err;

    serial_alu_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .z      (z),
        .n      (n),
        .c      (c),
        .v      (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {z, n, c, v, result}.
    function automatic logic [11:0] model(input logic [1:0] o,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
        int unsigned s;
        logic [7:0]  r;
        logic        fc, fv;
        fc = 1'b0;
        fv = 1'b0;
        case (o)
            2'd0: begin
                s  = int'(x) + int'(y);
                r  = s[7:0];
                fc = (s > 255);
                fv = (x[7] == y[7]) && (r[7] != x[7]);
            end
            2'd1: begin
                r  = x - y;
                fc = (x >= y);
                fv = (x[7] != y[7]) && (r[7] != x[7]);
            end
            2'd2: r = x & y;
            default: r = x | y;
        endcase
        return {(r == 8'h00), r[7], fc, fv, r};
    endfunction

    // Runs one word. With pre set, start was already driven in the
    // previous done cycle. Returns at the negedge where done is seen.
    task automatic xact(input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input int glitch,
                        input bit pre);
        logic [11:0] exp;
        logic [7:0]  held;
        int          cyc;
        int          nbusy;
        int          bad;
        exp = model(o, x, y);
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
            op    = o;
            a     = x;
            b     = y;
        end
        held = result;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        nbusy = 0;
        bad   = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if (result !== held) bad++;
            if (cyc == glitch) begin
                start = 1'b1;
                op    = 2'($urandom);
                a     = 8'($urandom);
                b     = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'd8);
        chk("busy_cycles", 32'(nbusy), 32'd8);
        chk("busy_and_done", 32'(busy & done), 32'd0);
        chk("result_stable", 32'(bad), 32'd0);
        chk("result", 32'(result), 32'(exp[7:0]));
        chk("flags_zncv", 32'({z, n, c, v}), 32'(exp[11:8]));
    endtask

    logic [1:0] dop [7];
    logic [7:0] da  [7];
    logic [7:0] db  [7];

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 8'h00;
        b     = 8'h00;

        dop = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        da  = '{8'h7F, 8'h05, 8'h00, 8'hF0, 8'h00, 8'hFF, 8'h80};
        db  = '{8'h01, 8'h05, 8'h01, 8'h3C, 8'h00, 8'h01, 8'h80};

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({z, n, c, v}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (dop[i]) xact(dop[i], da[i], db[i], -1, 1'b0);

        // start pulsed mid-RUN is ignored
        xact(2'd0, 8'h12, 8'h34, 3, 1'b0);
        @(negedge clk);
        chk("single_done", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);

        // back-to-back: start held into DONE
        xact(2'd0, 8'h7F, 8'h01, -1, 1'b0);
        start = 1'b1;
        op    = 2'd1;
        a     = 8'h10;
        b     = 8'h20;
        xact(2'd1, 8'h10, 8'h20, -1, 1'b1);

        // reset at bit 3 of an add
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        a     = 8'h55;
        b     = 8'h22;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_flags", 32'({z, n, c, v}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int nd;
            nd = 0;
            repeat (12) begin
                @(negedge clk);
                if (done || busy) nd++;
            end
            chk("no_done_after_rst", 32'(nd), 32'd0);
        end
        xact(2'd0, 8'h55, 8'h22, -1, 1'b0);

        repeat (40) begin
            xact(2'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
